sad_row_gen: RTL and testbench
==============================

// Module: sad_row_gen
// PURPOSE
//   Producer side of the SAD-to-compare interface in the full-search block matcher.
//   Takes a 4x4 current block and its reference pixels, one pixel per beat.
//   Computes 16 candidate SADs (dx=0..15) in parallel for one search row (dy).
//   Presents them as sum0..sum15 with ctrl_wd=dy and a one-cycle enable strobe
//   to the downstream minimum/motion-vector compare stage. Sweeps dy=0..15 per search.
// PARAMETERS
//   PIX_W   8   pixel width, unsigned
//   N_PIX   16  pixels per block (4x4, raster order); beats per row
//   SUM_W   12  accumulator/output width; must be >= PIX_W+log2(N_PIX) unless SAD_SATURATE_EN
//   (candidate count fixed at 16, row count fixed at 16: matches 4-bit mvx/mvy)
// PORTS
//   clk        in   1         clock, all state updates on rising edge
//   rst        in   1         reset, asynchronous, active-high
//   start      in   1         begin a 16-row search; sampled only in IDLE
//   in_valid   in   1         cur_pix/ref_vec valid this cycle
//   in_ready   out  1         block accepts a beat; beat transfers when in_valid&in_ready
//   cur_pix    in   PIX_W     current-block pixel k (k = beat index within row)
//   ref_vec    in   16*PIX_W  ref pixel for pixel k at dx=i in bits [i*PIX_W +: PIX_W]
//   sum0..sum15 out SUM_W     SAD of candidate dx=0..15 for row ctrl_wd, held until next row
//   ctrl_wd    out  4         row index dy of presented sums
//   enable     out  1         one-cycle strobe: sum0..15/ctrl_wd newly valid
//   busy       out  1         high in ACC and DONE
//   done       out  1         one-cycle strobe after row 15 presented
// BEHAVIOUR
//   - Reset: state=IDLE; accumulators, sum0..15, ctrl_wd, beat/row counters = 0.
//     enable, done, busy, in_ready = 0.
//   - FSM IDLE -> ACC on start. ACC: in_ready=1, busy=1.
//     ACC -> DONE after 16th beat of row 15. DONE (1 cycle): done=1 -> IDLE.
//   - Per accepted beat: acc[i] += |cur_pix - ref_vec[i]| for i=0..15.
//     |a-b| is computed unsigned on PIX_W bits and zero-extended to SUM_W.
//     Beat counter increments 0..N_PIX-1.
//   - On the 16th beat of a row (same edge as that beat's accumulate):
//     sum_i <= acc[i]+|diff_i|; ctrl_wd <= row; acc <= 0; beat <= 0; row++.
//     enable=1 during the following cycle only. Latency: last beat -> enable = 1 cycle.
//   - No stall between rows: the beat right after a row end accumulates into cleared accs.
//   - in_valid=0 in ACC: no state change; gaps allowed at any beat.
//   - start asserted outside IDLE: ignored. start with in_valid same cycle in IDLE: beat not
//     accepted (in_ready=0 in IDLE).
//   - After row 15: row counter wraps to 0. sum0..15/ctrl_wd=15 held through IDLE
//     until next search's row 0 completes.
//   - rst mid-row: partial sums discarded; all outputs return to reset values immediately.
//   - Sum overflow without macro: modulo 2^SUM_W wrap (unreachable at defaults: max 4080).
// CONFIGURATION
//   SAD_SATURATE_EN defined: each accumulate clamps at 2^SUM_W-1 (sticky).
//     Applies to acc and to the transferred sum_i.
//   SAD_SATURATE_EN undefined: plain modulo-2^SUM_W addition, no clamp logic.
// TESTING
//   1 Reset: rst=1 mid-ACC -> in_ready=0, enable=0, sums=0, ctrl_wd=0 within same cycle.
//   2 start; 256 beats cur=10, ref[i]=10+i -> 16 enable strobes, ctrl_wd 0..15.
//     sum_i=16*i each row (sum15=240); done one cycle after last enable.
//   3 Row 0 cur=255, all ref=0 -> sum0..15=4080 (no wrap/clamp).
//     Row 1 cur=0, ref=0 -> all 0.
//   4 Random in_valid gaps (~50%) over a full search -> sums identical to gap-free run.
//     Exactly 16 enables.
//   5 start pulsed during ACC row 7 -> ignored; row sequence continues 8..15, single done.
//   6 PIX_W=10, SUM_W=12, cur=1023, ref=0: with SAD_SATURATE_EN -> sum=4095.
//     Without -> sum=(16*1023) mod 4096=4080.

Source files
------------

// File: rtl/sad_row_gen.sv
// SAD row generator: accumulates 16 candidate SADs (dx=0..15) for one search row per
// N_PIX beats and sweeps dy=0..15. Optional clamp when SAD_SATURATE_EN is defined.
module sad_row_gen #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned N_PIX = 16,
  parameter int unsigned SUM_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PIX_W-1:0]     cur_pix,
  input  logic [16*PIX_W-1:0]  ref_vec,
  output logic [SUM_W-1:0]     sum0,
  output logic [SUM_W-1:0]     sum1,
  output logic [SUM_W-1:0]     sum2,
  output logic [SUM_W-1:0]     sum3,
  output logic [SUM_W-1:0]     sum4,
  output logic [SUM_W-1:0]     sum5,
  output logic [SUM_W-1:0]     sum6,
  output logic [SUM_W-1:0]     sum7,
  output logic [SUM_W-1:0]     sum8,
  output logic [SUM_W-1:0]     sum9,
  output logic [SUM_W-1:0]     sum10,
  output logic [SUM_W-1:0]     sum11,
  output logic [SUM_W-1:0]     sum12,
  output logic [SUM_W-1:0]     sum13,
  output logic [SUM_W-1:0]     sum14,
  output logic [SUM_W-1:0]     sum15,
  output logic [3:0]           ctrl_wd,
  output logic                 enable,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned N_CAND = 16;
  localparam int unsigned BEAT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_PIX - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat;
  logic [3:0]        row;
  logic [SUM_W-1:0]  diff     [N_CAND];
  logic [SUM_W-1:0]  acc_next [N_CAND];
  logic [SUM_W-1:0]  acc      [N_CAND];
  logic [SUM_W-1:0]  sum_q    [N_CAND];
`ifdef SAD_SATURATE_EN
  logic [SUM_W:0]    acc_wide [N_CAND];
`endif

  // Per-candidate absolute difference and the accumulator value after this beat
  always_comb begin
    for (int i = 0; i < N_CAND; i++) begin
      diff[i] = (cur_pix >= ref_vec[i*PIX_W +: PIX_W])
              ? SUM_W'(cur_pix - ref_vec[i*PIX_W +: PIX_W])
              : SUM_W'(ref_vec[i*PIX_W +: PIX_W] - cur_pix);
`ifdef SAD_SATURATE_EN
      acc_wide[i] = {1'b0, acc[i]} + {1'b0, diff[i]};
      acc_next[i] = acc_wide[i][SUM_W] ? {SUM_W{1'b1}} : acc_wide[i][SUM_W-1:0];
`else
      acc_next[i] = acc[i] + diff[i];
`endif
    end
  end

  // Control FSM, counters, accumulators and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      beat     <= '0;
      row      <= '0;
      ctrl_wd  <= '0;
      enable   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      for (int i = 0; i < N_CAND; i++) begin
        acc[i]   <= '0;
        sum_q[i] <= '0;
      end
    end else begin
      enable <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACC;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACC: begin
          if (in_valid && in_ready) begin
            if (beat == LAST_BEAT) begin
              for (int i = 0; i < N_CAND; i++) begin
                sum_q[i] <= acc_next[i];
                acc[i]   <= '0;
              end
              ctrl_wd <= row;
              beat    <= '0;
              row     <= row + 4'd1;
              enable  <= 1'b1;
              if (row == 4'd15) begin
                state    <= DONE;
                in_ready <= 1'b0;
              end
            end else begin
              for (int i = 0; i < N_CAND; i++) acc[i] <= acc_next[i];
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sum0  = sum_q[0];
  assign sum1  = sum_q[1];
  assign sum2  = sum_q[2];
  assign sum3  = sum_q[3];
  assign sum4  = sum_q[4];
  assign sum5  = sum_q[5];
  assign sum6  = sum_q[6];
  assign sum7  = sum_q[7];
  assign sum8  = sum_q[8];
  assign sum9  = sum_q[9];
  assign sum10 = sum_q[10];
  assign sum11 = sum_q[11];
  assign sum12 = sum_q[12];
  assign sum13 = sum_q[13];
  assign sum14 = sum_q[14];
  assign sum15 = sum_q[15];

endmodule

// File: tb/tb_sad_row_gen.sv
// Bench for sad_row_gen: directed searches checked against a behavioural SAD model,
// plus literal pins and a wide-pixel instance for the wrap/clamp case.
module tb_sad_row_gen;

  localparam int unsigned SUM_W = 12;
  localparam int          SUM_MAX = (1 << SUM_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance, default parameters
  logic         start = 1'b0, in_valid = 1'b0;
  logic         in_ready, enable, busy, done;
  logic [7:0]   cur_pix = '0;
  logic [127:0] ref_vec = '0;
  logic [11:0]  s [16];
  logic [3:0]   ctrl_wd;

  sad_row_gen dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .cur_pix(cur_pix), .ref_vec(ref_vec),
    .sum0(s[0]), .sum1(s[1]), .sum2(s[2]), .sum3(s[3]), .sum4(s[4]), .sum5(s[5]),
    .sum6(s[6]), .sum7(s[7]), .sum8(s[8]), .sum9(s[9]), .sum10(s[10]), .sum11(s[11]),
    .sum12(s[12]), .sum13(s[13]), .sum14(s[14]), .sum15(s[15]),
    .ctrl_wd(ctrl_wd), .enable(enable), .busy(busy), .done(done)
  );

  // wide-pixel instance
  logic         start2 = 1'b0, in_valid2 = 1'b0;
  logic         in_ready2, enable2, busy2, done2;
  logic [9:0]   cur2 = '0;
  logic [159:0] ref2 = '0;
  logic [11:0]  s2 [16];
  logic [3:0]   ctrl_wd2;

  sad_row_gen #(.PIX_W(10), .N_PIX(16), .SUM_W(12)) dut_w (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
    .cur_pix(cur2), .ref_vec(ref2),
    .sum0(s2[0]), .sum1(s2[1]), .sum2(s2[2]), .sum3(s2[3]), .sum4(s2[4]), .sum5(s2[5]),
    .sum6(s2[6]), .sum7(s2[7]), .sum8(s2[8]), .sum9(s2[9]), .sum10(s2[10]), .sum11(s2[11]),
    .sum12(s2[12]), .sum13(s2[13]), .sum14(s2[14]), .sum15(s2[15]),
    .ctrl_wd(ctrl_wd2), .enable(enable2), .busy(busy2), .done(done2)
  );

  int n_pass = 0, n_total = 0;
  int en_count = 0, done_count = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int clamp_sum(input int v);
`ifdef SAD_SATURATE_EN
    return (v > SUM_MAX) ? SUM_MAX : v;
`else
    return v % (SUM_MAX + 1);
`endif
  endfunction

  // Behavioural model: totals of |cur-ref| per candidate over each group of 16 accepted beats
  int m_tot [16];
  int m_beat = 0, m_row = 0;
  int e_sum [16];
  int e_row = 0;
  bit e_en = 0, e_done = 0, e_done_pend = 0;

  always @(negedge clk) begin
    if (rst) begin
      foreach (m_tot[i]) m_tot[i] = 0;
      m_beat = 0; m_row = 0;
      e_en = 0; e_done = 0; e_done_pend = 0;
    end else begin
      chk("enable", int'(enable), int'(e_en));
      if (enable) en_count++;
      if (done) done_count++;
      if (e_en) begin
        chk("ctrl_wd", int'(ctrl_wd), e_row);
        for (int i = 0; i < 16; i++) chk($sformatf("sum%0d", i), int'(s[i]), e_sum[i]);
      end
      chk("done", int'(done), int'(e_done));
      e_done = e_done_pend;
      e_done_pend = 0;
      e_en = 0;
      if (in_valid && in_ready) begin
        for (int i = 0; i < 16; i++) begin
          int c, r;
          c = int'(cur_pix);
          r = int'(ref_vec[i*8 +: 8]);
          m_tot[i] = clamp_sum(m_tot[i] + ((c > r) ? c - r : r - c));
        end
        m_beat++;
        if (m_beat == 16) begin
          foreach (e_sum[i]) e_sum[i] = m_tot[i];
          e_row = m_row;
          e_en = 1;
          if (m_row == 15) e_done_pend = 1;
          m_row = (m_row + 1) % 16;
          m_beat = 0;
          foreach (m_tot[i]) m_tot[i] = 0;
        end
      end
    end
  end

  task automatic gen(input int mode, input int r, output logic [7:0] c, output logic [127:0] rv);
    rv = '0;
    if (mode == 0) begin
      c = 8'd10;
      for (int i = 0; i < 16; i++) rv[i*8 +: 8] = 8'(10 + i);
    end else if (mode == 1 && r == 0) begin
      c = 8'd255;
    end else if (mode == 1 && r == 1) begin
      c = 8'd0;
    end else begin
      c = 8'($urandom_range(0, 255));
      for (int i = 0; i < 16; i++) rv[i*8 +: 8] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic drive_beat(input logic [7:0] c, input logic [127:0] rv, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 99) < 50) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    cur_pix = c; ref_vec = rv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_search(input int mode, input bit gaps, input bit start_mid);
    int en0, dn0;
    logic [7:0] c;
    logic [127:0] rv;
    en0 = en_count; dn0 = done_count;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk("busy_in_acc", int'(busy), 1);
    for (int r = 0; r < 16; r++) begin
      for (int b = 0; b < 16; b++) begin
        gen(mode, r, c, rv);
        if (start_mid && r == 7 && b == 5) start = 1'b1;
        drive_beat(c, rv, gaps);
        start = 1'b0;
      end
      if (mode == 1 && r == 0) begin
        chk("row0_sum0_4080", int'(s[0]), 4080);
        chk("row0_sum15_4080", int'(s[15]), 4080);
      end
      if (mode == 1 && r == 1) chk("row1_sum7_zero", int'(s[7]), 0);
      if (start_mid && r == 8) chk("row8_after_mid_start", int'(ctrl_wd), 8);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("enables_per_search", en_count - en0, 16);
    chk("dones_per_search", done_count - dn0, 1);
    chk("idle_in_ready", int'(in_ready), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    logic [7:0] c;
    logic [127:0] rv;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_sum0", int'(s[0]), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // mid-ACC reset: complete row 0, then reset while its enable is high
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int b = 0; b < 16; b++) begin
      gen(0, 0, c, rv);
      drive_beat(c, rv, 1'b0);
    end
    chk("row0_enable_before_reset", int'(enable), 1);
    chk("row0_sum15_before_reset", int'(s[15]), 240);
    rst = 1'b1; #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_sum15", int'(s[15]), 0);
    chk("rst_ctrl_wd", int'(ctrl_wd), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_search(0, 1'b0, 1'b0);
    chk("lit_sum15_240", int'(s[15]), 240);
    chk("lit_sum1_16", int'(s[1]), 16);
    chk("lit_ctrl_wd_15_held", int'(ctrl_wd), 15);
    run_search(1, 1'b0, 1'b0);
    run_search(2, 1'b1, 1'b0);
    run_search(3, 1'b0, 1'b1);

    // wide pixels: 16 * 1023 either clamps or wraps
    start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
    chk("w_in_ready", int'(in_ready2), 1);
    cur2 = 10'd1023; ref2 = '0;
    in_valid2 = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    chk("w_enable", int'(enable2), 1);
    chk("w_ctrl_wd", int'(ctrl_wd2), 0);
    chk("w_busy", int'(busy2), 1);
    chk("w_done", int'(done2), 0);
`ifdef SAD_SATURATE_EN
    for (int i = 0; i < 16; i++) chk($sformatf("w_sum%0d", i), int'(s2[i]), 4095);
`else
    for (int i = 0; i < 16; i++) chk($sformatf("w_sum%0d", i), int'(s2[i]), 4080);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
